// File: rtl/axi4s_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI4-Stream round-robin arbiter.
package axi4s_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Modulo increment of the round-robin pointer; NREQ-1 wraps to 0.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
      return (ptr + 1 >= nreq) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/axi4s_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request bit at or above base, wrapping.
module rr_pick #(
   parameter int NREQ  = 4,
   parameter int IDLEN = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDLEN-1:0] base,
   output logic             found,
   output logic [IDLEN-1:0] index
);

   logic [IDLEN:0] sum;

   // One spare bit holds base+k before the modulo-NREQ fold.
   always_comb begin
      found = 1'b0;
      index = '0;
      sum   = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, base} + (IDLEN+1)'(k);
         if (sum >= (IDLEN+1)'(NREQ)) begin
            sum = sum - (IDLEN+1)'(NREQ);
         end
         if (!found && req[sum[IDLEN-1:0]]) begin
            found = 1'b1;
            index = sum[IDLEN-1:0];
         end
      end
   end

endmodule

// File: rtl/axi4s_rr_arbiter.sv
// Merges NREQ AXI4-Stream requesters onto one registered output, holding the grant for a whole packet.
module axi4s_rr_arbiter
   import axi4s_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DLEN  = 32,
   parameter int IDLEN = $clog2(NREQ)
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [NREQ-1:0]      s_tvalid,
   output logic [NREQ-1:0]      s_tready,
   input  logic [NREQ*DLEN-1:0] s_tdata,
   input  logic [NREQ-1:0]      s_tlast,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic [DLEN-1:0]      m_tdata,
   output logic                 m_tlast,
   output logic [IDLEN-1:0]     m_tid
);

   state_t           state;
   state_t           state_next;
   logic [IDLEN-1:0] grant;
   logic [IDLEN-1:0] rr_ptr;
   logic [IDLEN-1:0] pick_index;
   logic             pick_found;
   logic             out_free;
   logic             accept;
   logic [DLEN-1:0]  sel_data;
   logic             sel_last;
   logic             sel_valid;

   rr_pick #(
      .NREQ  (NREQ),
      .IDLEN (IDLEN)
   ) u_pick (
      .req   (s_tvalid),
      .base  (rr_ptr),
      .found (pick_found),
      .index (pick_index)
   );

   // Ready depends only on the output register and m_tready, never on s_tvalid.
   assign out_free = ~m_tvalid | m_tready;
   assign accept   = (state == BUSY) && sel_valid && out_free;

   always_comb begin
      sel_data  = '0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      s_tready  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == IDLEN'(i)) begin
            sel_data    = s_tdata[i*DLEN +: DLEN];
            sel_last    = s_tlast[i];
            sel_valid   = s_tvalid[i];
            s_tready[i] = (state == BUSY) && out_free;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (pick_found) state_next = BUSY;
         BUSY: if (accept && sel_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A drain without a fresh accept empties the output register; a drain with one replaces it.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
         m_tid    <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && pick_found) begin
            grant <= pick_index;
         end
         if (accept) begin
            m_tvalid <= 1'b1;
            m_tdata  <= sel_data;
            m_tlast  <= sel_last;
            m_tid    <= grant;
            if (sel_last) begin
               rr_ptr <= IDLEN'(rr_next(32'(grant), NREQ));
            end
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end

endmodule
